// File: rtl/key_event_pkg.sv
// Shared types and constants for the key_event debounce/auto-repeat stage.
// Holds the FSM state enum, key code width, null key and a saturating increment.
package key_event_pkg;

  localparam int KEY_CODE_W = 5;
  localparam logic [KEY_CODE_W-1:0] KEY_NULL = 5'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_REPEAT,
    S_RELEASE
  } key_ev_state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
// Ports: mclk clock, rst sync active-high reset, tick terminal-count pulse.
module ms_tick #(
  parameter int DIV = 32000
) (
  input  logic mclk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/key_event.sv
// Keypad debounce + auto-repeat with a one-entry valid/ready event buffer.
// Ports: mclk, rst, key_code in; ev_valid/ev_ready/ev_code/ev_repeat, held_code, ovf.
module key_event
  import key_event_pkg::*;
#(
  parameter int CLK_HZ          = 32_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic [KEY_CODE_W-1:0] key_code,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [KEY_CODE_W-1:0] ev_code,
  output logic                  ev_repeat,
  output logic [KEY_CODE_W-1:0] held_code,
  output logic                  ovf
);

  localparam logic [15:0] DB_T = 16'(DEBOUNCE_MS);
  localparam logic [15:0] RD_T = 16'(REPEAT_DELAY_MS);
  localparam logic [15:0] RR_T = 16'(REPEAT_RATE_MS);

  logic                  tick;
  logic [KEY_CODE_W-1:0] k_s;
  key_ev_state_t         state, state_n;
  logic [KEY_CODE_W-1:0] cand, cand_n;
  logic [15:0]           ms_cnt, cnt_n;
  logic [15:0]           inc;
  logic [15:0]           thr;
  logic [KEY_CODE_W-1:0] held_n;
  logic                  gen;
  logic                  gen_rep;

  ms_tick #(
    .DIV (CLK_HZ / 1000)
  ) u_tick (
    .mclk (mclk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge mclk) begin
    if (rst) begin
      k_s       <= KEY_NULL;
      state     <= S_IDLE;
      cand      <= KEY_NULL;
      ms_cnt    <= '0;
      held_code <= KEY_NULL;
    end else begin
      k_s       <= key_code;
      state     <= state_n;
      cand      <= cand_n;
      ms_cnt    <= cnt_n;
      held_code <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = ms_cnt;
    gen     = 1'b0;
    gen_rep = 1'b0;
    inc     = sat_inc(ms_cnt);
    thr     = (state == S_HELD) ? RD_T : RR_T;
    unique case (state)
      S_IDLE: begin
        if (k_s != KEY_NULL) begin
          cand_n  = k_s;
          cnt_n   = '0;
          state_n = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (k_s == KEY_NULL) begin
          state_n = S_IDLE;
        end else if (k_s != cand) begin
          cand_n = k_s;
          cnt_n  = '0;
        end else if (tick) begin
          if (inc >= DB_T) begin
            gen     = 1'b1;
            cnt_n   = '0;
            state_n = S_HELD;
          end else begin
            cnt_n = inc;
          end
        end
      end
      S_HELD, S_REPEAT: begin
        if (k_s != cand) begin
          cnt_n   = '0;
          state_n = S_RELEASE;
        end else if (tick) begin
          if (inc >= thr) begin
            gen     = 1'b1;
            gen_rep = 1'b1;
            cnt_n   = '0;
            state_n = S_REPEAT;
          end else begin
            cnt_n = inc;
          end
        end
      end
      S_RELEASE: begin
        if (k_s == KEY_NULL) begin
          if (tick) begin
            if (inc >= DB_T) begin
              cnt_n   = '0;
              state_n = S_IDLE;
            end else begin
              cnt_n = inc;
            end
          end
        end else if (k_s == cand) begin
          // bounce back to the same key: resume hold, no new press
          cnt_n   = '0;
          state_n = S_HELD;
        end else begin
          // a different key must wait for a full release first
          cnt_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    held_n = ((state_n == S_HELD) || (state_n == S_REPEAT) ||
              (state_n == S_RELEASE)) ? cand_n : KEY_NULL;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      ev_valid  <= 1'b0;
      ev_code   <= KEY_NULL;
      ev_repeat <= 1'b0;
      ovf       <= 1'b0;
    end else if (gen) begin
      if (!ev_valid || ev_ready) begin
        ev_valid  <= 1'b1;
        ev_code   <= cand;
        ev_repeat <= gen_rep;
      end else begin
        ovf <= 1'b1;
      end
    end else if (ev_valid && ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

endmodule
